// File: rtl/fs_nibble_sub.sv
// fs_nibble_sub: multi-cycle WIDTH-bit subtractor (a - b - bin), one 4-bit slice per clock, LSB first.
// Optional signed overflow flag enabled by defining FS_NIBBLE_SUB_OVF_EN.
module fs_nibble_sub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);
  localparam int NIB = WIDTH / 4;
  localparam int CW = $clog2(NIB + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_sh, b_sh, acc, acc_n;
  logic carry;
  logic [4:0] sl;
  assign sl = {1'b0, a_sh[3:0]} + {1'b0, ~b_sh[3:0]} + {4'b0, carry};
  assign acc_n = (WIDTH'(sl[3:0]) << (WIDTH - 4)) | (acc >> 4);
`ifdef FS_NIBBLE_SUB_OVF_EN
  logic a_msb, b_msb;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (state == IDLE && in_valid && in_ready) begin
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
      end
      if (state == BUSY && cnt == CW'(NIB - 1))
        ovf <= (a_msb != b_msb) && (sl[3] != a_msb);
    end
`else
  assign ovf = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      acc       <= '0;
      carry     <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            a_sh     <= a;
            b_sh     <= b;
            carry    <= ~bin;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          a_sh  <= a_sh >> 4;
          b_sh  <= b_sh >> 4;
          carry <= sl[4];
          acc   <= acc_n;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(NIB - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            diff      <= acc_n;
            bout      <= ~sl[4];
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule
